// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory latency arbiter.
// Also used by chip_top for the default memory latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } arb_state_t;

  localparam int unsigned DEFAULT_LATENCY = 2;

  // Index width for n ports, never below one bit.
  function automatic int unsigned idx_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above last_grant.
// Reused for bus arbitration in the multicore interconnect.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  localparam int unsigned GW = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GW-1:0]        last_grant,
  output logic                 gnt_valid,
  output logic [GW-1:0]        gnt_idx
);

  int unsigned p;

  // Scan downward in distance so the nearest requester wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    p         = 0;
    for (int unsigned k = NUM_PORTS; k >= 1; k--) begin
      p = (int'(last_grant) + k) % NUM_PORTS;
      if (req[p]) begin
        gnt_valid = 1'b1;
        gnt_idx   = GW'(p);
      end
    end
  end

endmodule

// File: rtl/mem_latency_arbiter.sv
// N-port round-robin main-memory arbiter with fixed wait latency.
// Define MEM_LAT_ARB_PERF_CNT_EN to add per-port stall counters.
module mem_latency_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LATENCY    = DEFAULT_LATENCY,
  parameter int unsigned CNT_WIDTH  = 4,
  localparam int unsigned GW = idx_w(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  output logic [NUM_PORTS-1:0]            ready,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [GW-1:0]                   grant_id,
  output logic                            busy
`ifdef MEM_LAT_ARB_PERF_CNT_EN
  ,
  output logic [NUM_PORTS*32-1:0]         stall_cycles
`endif
);

  arb_state_t state_q, state_d;

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]  ready_q, ready_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [GW-1:0]         grant_id_q, grant_id_d;
  logic [GW-1:0]         last_q, last_d;
  logic                  busy_q, busy_d;

  logic                  gnt_valid;
  logic [GW-1:0]         gnt_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  cur_req;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr (
    .req        (req),
    .last_grant (last_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign win_addr = addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign cur_addr = addr[int'(grant_id_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign cur_req  = req[grant_id_q];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = '0;
    mem_addr_d = mem_addr_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    busy_d     = busy_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant_id_d = gnt_idx;
          last_d     = gnt_idx;
          mem_addr_d = win_addr;
          cnt_d      = CNT_WIDTH'(1);
          busy_d     = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (!cur_req) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cur_addr != mem_addr_q) begin
          // Requester moved on to a new word: restart the wait.
          mem_addr_d = cur_addr;
          cnt_d      = CNT_WIDTH'(1);
        end else if (cnt_q == CNT_WIDTH'(LATENCY)) begin
          ready_d = NUM_PORTS'(1) << grant_id_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= '0;
      mem_addr_q <= '0;
      grant_id_q <= '0;
      last_q     <= GW'(NUM_PORTS - 1);
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      mem_addr_q <= mem_addr_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
    end
  end

  assign ready    = ready_q;
  assign mem_addr = mem_addr_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

`ifdef MEM_LAT_ARB_PERF_CNT_EN
  logic [NUM_PORTS-1:0][31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      stall_d[i] = stall_q[i] + 32'(req[i] & ~ready_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mem_latency_arbiter.sv
// Random and directed bench for mem_latency_arbiter against a
// transaction-level model using absolute deadline edges.
module tb_mem_latency_arbiter;

  localparam int NP  = 4;
  localparam int AW  = 16;
  localparam int LAT = 3;
  localparam int CW  = 4;
  localparam int GW  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    req;
  logic [NP*AW-1:0] addr;
  logic [NP-1:0]    ready;
  logic [AW-1:0]    mem_addr;
  logic [GW-1:0]    grant_id;
  logic             busy;
`ifdef MEM_LAT_ARB_PERF_CNT_EN
  logic [NP*32-1:0] stall_cycles;
`endif

  mem_latency_arbiter #(
    .NUM_PORTS  (NP),
    .ADDR_WIDTH (AW),
    .LATENCY    (LAT),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .addr     (addr),
    .ready    (ready),
    .mem_addr (mem_addr),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef MEM_LAT_ARB_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Requester-side address per port
  logic [AW-1:0] a [NP];

  // Reference model state
  int            e_n;
  int            m_owner;
  bit            m_resp;
  int            m_deadline;
  int            m_last;
  logic [AW-1:0] m_addr;
  int            m_gid;
  logic [NP-1:0] m_ready;
  bit            m_busy;
  int unsigned   m_stall [NP];

  task automatic pack();
    for (int i = 0; i < NP; i++) addr[i*AW +: AW] = a[i];
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_resp   = 0;
    m_last   = NP - 1;
    m_addr   = '0;
    m_gid    = 0;
    m_ready  = '0;
    m_busy   = 0;
    m_deadline = 0;
    for (int i = 0; i < NP; i++) m_stall[i] = 0;
  endtask

  // One rising edge: ownership is granted, aborted, restarted, or
  // completes at grant/restart edge + LAT.
  task automatic model_edge();
    logic [NP-1:0] prev;
    bit found;
    int p;
    prev = m_ready;
    for (int i = 0; i < NP; i++)
      if (req[i] && !prev[i]) m_stall[i]++;
    m_ready = '0;
    if (m_resp) begin
      m_resp  = 0;
      m_busy  = 0;
      m_owner = -1;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= NP; k++) begin
        p = (m_last + k) % NP;
        if (!found && req[p]) begin
          found      = 1;
          m_owner    = p;
          m_gid      = p;
          m_last     = p;
          m_addr     = addr[p*AW +: AW];
          m_deadline = e_n + LAT;
          m_busy     = 1;
        end
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
      m_busy  = 0;
    end else if (addr[m_owner*AW +: AW] != m_addr) begin
      m_addr     = addr[m_owner*AW +: AW];
      m_deadline = e_n + LAT;
    end else if (e_n == m_deadline) begin
      m_resp = 1;
      m_ready[m_owner] = 1'b1;
    end
    e_n++;
  endtask

  task automatic compare();
    chk("ready", ready, m_ready);
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_gid);
    chk("mem_addr", mem_addr, m_addr);
`ifdef MEM_LAT_ARB_PERF_CNT_EN
    for (int i = 0; i < NP; i++)
      chk("stall", stall_cycles[i*32 +: 32], m_stall[i]);
`endif
  endtask

  task automatic drive_rand();
    int r;
    for (int i = 0; i < NP; i++) begin
      r = $urandom_range(99);
      if (!req[i]) begin
        if (r < 35) begin
          req[i] = 1'b1;
          a[i]   = AW'($urandom_range(7) * 4);
        end
      end else if (m_ready[i]) begin
        if (r < 50) req[i] = 1'b0;
        else a[i] = a[i] + AW'(4);
      end else if (r < 3) begin
        req[i] = 1'b0;
      end else if (r < 7) begin
        a[i] = a[i] + AW'(4);
      end
    end
    pack();
  endtask

  task automatic drive_dir();
    for (int i = 0; i < NP; i++)
      if (m_ready[i]) a[i] = a[i] + AW'(4);
    pack();
  endtask

  task automatic run(input int n, input bit rnd);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
      if (rnd) drive_rand();
      else drive_dir();
    end
  endtask

  bit got_rdy;

  initial begin
    e_n   = 0;
    req   = '0;
    for (int i = 0; i < NP; i++) a[i] = '0;
    pack();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_maddr", mem_addr, 0);
    rst_n = 1'b1;

    // Single request on port 0
    req[0] = 1'b1;
    a[0]   = 16'h0100;
    pack();
    run(1, 0);
    chk("single_busy0", busy, 1);
    chk("single_maddr", mem_addr, 16'h0100);
    run(LAT - 1, 0);
    chk("single_norw", ready, 0);
    run(1, 0);
    chk("single_ready", ready, 4'b0001);
    chk("single_gid", grant_id, 0);
    req[0] = 1'b0;
    pack();
    run(1, 0);
    chk("single_done", {ready, busy}, 0);

    run(700, 1);

    // Find an in-flight wait, then reset asynchronously
    got_rdy = 0;
    for (int t = 0; t < 60; t++) begin
      if (!got_rdy) begin
        if (m_busy && !m_resp) got_rdy = 1;
        else run(1, 1);
      end
    end
    chk("find_wait", got_rdy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_gid", grant_id, 0);
    chk("arst_maddr", mem_addr, 0);
    model_reset();
    @(negedge clk);
    req = '1;
    for (int i = 0; i < NP; i++) a[i] = AW'(16'h0200 + i * 16'h40);
    pack();
    rst_n = 1'b1;

    // All ports contend: ready order 0,1,2,3
    for (int j = 0; j < NP; j++) begin
      got_rdy = 0;
      for (int t = 0; t < 20; t++) begin
        if (!got_rdy) begin
          run(1, 0);
          if (ready != 0) got_rdy = 1;
        end
      end
      chk("rr_seen", got_rdy, 1);
      chk("rr_order", ready, NP'(1) << j);
    end

    run(700, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_latency_arbiter.md
Name: mem_latency_arbiter

Overview:
- Parametrised unified-memory access arbiter with a latency model.
- Sits between the core's requesters (I-cache refill, D-cache or data port, future second core) and the single main_memory read port.
- Arbitrates N level-held requests round-robin and drives the winning address to memory.
- Returns a one-cycle ready pulse to the winner after a configurable number of wait cycles.
- Generalises the fixed 2-cycle, single-requester ready generator to N ports.

Parameters:
- NUM_PORTS, 2, number of requester channels (legal range 1..8).
- ADDR_WIDTH, 32, request address width.
- LATENCY, 2, wait cycles per word (legal range 1..15).
- CNT_WIDTH, 4, latency counter width; must satisfy 2^CNT_WIDTH > LATENCY.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_PORTS  per-port request; held high until ready or abort.
- addr  input  NUM_PORTS*ADDR_WIDTH  per-port word address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- ready  output  NUM_PORTS  one-hot, one-cycle pulse; read data for the granted port is valid this cycle.
- mem_addr  output  ADDR_WIDTH  address presented to main memory (latched grant address).
- grant_id  output  $clog2(NUM_PORTS) (minimum 1)  index of the current owner.
- busy  output  1  high in WAIT and RESP.

Behaviour:
- Reset values: state=IDLE, cnt=0, ready=0, mem_addr=0, grant_id=0, busy=0, last_grant=NUM_PORTS-1 (so port 0 wins first).
- Reset is honoured mid-transaction: ready drops immediately (asynchronous clear), and no ready pulse is produced for the aborted transfer.
- FSM states are IDLE, WAIT and RESP. All outputs are registered.
- IDLE, any req high:
  - Round-robin pick: the first requesting port searching upward from last_grant+1, wrapping from NUM_PORTS-1 to 0.
  - Latch grant_id and mem_addr <= addr[grant]; set last_grant=grant, cnt=1; go to WAIT.
- IDLE, no req: remain in IDLE; outputs hold their values, ready=0.
- WAIT, each edge, evaluated in priority order:
  - req[grant_id] low (abort): go to IDLE with no ready pulse.
  - addr[grant_id] != mem_addr: latch the new address, cnt=1, stay in WAIT (new-request restart).
  - cnt==LATENCY: go to RESP and register ready[grant_id]=1.
  - Otherwise cnt++.
- RESP: ready is high for exactly one cycle; next edge clears ready and goes to IDLE.
- Latency: a request sampled in IDLE at edge k gives ready high in the cycle after edge k+LATENCY. The transfer occupies LATENCY+2 edges, and the next arbitration happens at edge k+LATENCY+2.
- Requester contract: in the cycle it sees ready, the requester either drops req or changes addr. Holding the same addr with req high is re-arbitrated as a new request.
- Arbitration happens only in IDLE. Requests arriving during WAIT or RESP wait their turn; no starvation is possible with round-robin.
- NUM_PORTS=1: the arbiter degenerates to the single-port behaviour and grant_id is constant 0.
- mem_addr holds its last value in IDLE (it is not driven to 0).

Optional Feature:
- Macro: MEM_LAT_ARB_PERF_CNT_EN.
- When defined:
  - Add output stall_cycles, NUM_PORTS*32 bits.
  - Per-port 32-bit counter increments every cycle that req[i]=1 and ready[i]=0.
  - Counters wrap at 2^32 and are reset to 0 by rst_n.
- When undefined: the port and counters are absent; no area cost.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum arb_state_t {IDLE, WAIT, RESP}.
  - Localparam helper for the grant index width.
  - Default LATENCY constant shared with chip_top.
- Sub-module rr_arbiter, purely combinational:
  - Inputs req and last_grant.
  - Outputs grant valid and grant index.
  - Reused later for bus arbitration in the multicore interconnect.

Test Plan:
- Single request: LATENCY=2, port 0 raises req with addr=0x100 at edge 0 → ready[0] pulses in the cycle after edge 2, mem_addr=0x100, grant_id=0, busy high for 3 cycles.
- Contention: ports 0 and 1 both request continuously, changing addr after each ready → grants alternate 0,1,0,1; each ready arrives exactly 4 edges after the previous one.
- Address restart: port 1 in WAIT at cnt=1 changes addr 0x200→0x204 → cnt restarts; ready[1] comes 2 edges after the change with mem_addr=0x204.
- Abort: port 0 drops req at cnt=1 → FSM returns to IDLE; no ready pulse; a pending port 1 is granted on the next edge.
- Reset mid-WAIT: rst_n low while busy=1 → ready, busy, grant_id and mem_addr go to 0 immediately; after release, port 0 wins the first arbitration.
- LATENCY=15, NUM_PORTS=4, with MEM_LAT_ARB_PERF_CNT_EN defined:
  - All four ports request simultaneously → round-robin order 0,1,2,3.
  - stall_cycles for port 3 equals 3*17+16=67 at its ready.
